// File: rtl/thv_cordic_log.sv
// thv_cordic_log: fully pipelined hyperbolic CORDIC in vectoring mode, z = atanh(y/x).
// Computes x = An*sqrt(x^2 - y^2), with y driven to ~0 and no gain compensation.
module thv_cordic_log #(
  parameter int WIDTH = 32,
  parameter int FRAC = 25,
  parameter int N_ITER = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic signed [WIDTH-1:0] x,
  input  logic signed [WIDTH-1:0] y,
  output logic signed [WIDTH-1:0] x_o,
  output logic signed [WIDTH-1:0] y_o,
  output logic signed [WIDTH-1:0] z_o
);
  localparam int STAGES = N_ITER + 2;
  // Shift indices 4 and 13 repeat, which hyperbolic CORDIC needs to converge.
  function automatic int shift_of(input int s);
    return s <= 4 ? s : s <= 14 ? s - 1 : s - 2;
  endfunction
  // atanh(2^-i) in Q7.25, rounded to nearest; from i = 9 on it equals 2^-i.
  function automatic logic signed [WIDTH-1:0] atanh_lut(input int i);
    case (i)
      1:       atanh_lut = WIDTH'(18431656);
      2:       atanh_lut = WIDTH'(8570232);
      3:       atanh_lut = WIDTH'(4216356);
      4:       atanh_lut = WIDTH'(2099889);
      5:       atanh_lut = WIDTH'(1048918);
      6:       atanh_lut = WIDTH'(524331);
      7:       atanh_lut = WIDTH'(262149);
      8:       atanh_lut = WIDTH'(131073);
      default: atanh_lut = WIDTH'(1) << (FRAC - i);
    endcase
  endfunction
  logic signed [WIDTH-1:0] xs [0:STAGES];
  logic signed [WIDTH-1:0] ys [0:STAGES];
  logic signed [WIDTH-1:0] zs [0:STAGES];
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int s = 0; s <= STAGES; s++) begin
        xs[s] <= '0;
        ys[s] <= '0;
        zs[s] <= '0;
      end
    end else begin
      xs[0] <= x;
      ys[0] <= y;
      zs[0] <= '0;
      for (int s = 1; s <= STAGES; s++) begin
        xs[s] <= ys[s-1][WIDTH-1] ? xs[s-1] + (ys[s-1] >>> shift_of(s)) : xs[s-1] - (ys[s-1] >>> shift_of(s));
        ys[s] <= ys[s-1][WIDTH-1] ? ys[s-1] + (xs[s-1] >>> shift_of(s)) : ys[s-1] - (xs[s-1] >>> shift_of(s));
        zs[s] <= ys[s-1][WIDTH-1] ? zs[s-1] - atanh_lut(shift_of(s)) : zs[s-1] + atanh_lut(shift_of(s));
      end
    end
  end
  assign x_o = xs[STAGES];
  assign y_o = ys[STAGES];
  assign z_o = zs[STAGES];
endmodule

// File: tb/tb_thv_cordic_log.sv
// tb_thv_cordic_log: directed vectors for thv_cordic_log with hand-computed Q7.25 expectations.
module tb_thv_cordic_log;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic signed [31:0] x = '0;
  logic signed [31:0] y = '0;
  logic signed [31:0] x_o, y_o, z_o;
  logic [31:0] acc;
  int n_chk = 0;
  int n_pass = 0;
  // 2.24/0.24, 2.5/0.5, 2.84/0.84, 2.5/-0.5, 1.0/0.0
  localparam logic signed [31:0] VX [5] = '{32'h047AE140, 32'h05000000, 32'h05AE1480, 32'h05000000, 32'h02000000};
  localparam logic signed [31:0] VY [5] = '{32'h007AE140, 32'h01000000, 32'h01AE1480, -32'sh01000000, 32'h00000000};
  localparam logic signed [31:0] VZ [5] = '{32'sd3609017, 32'sd6802590, 32'sd10230368, -32'sd6802590, 32'sd0};
  localparam logic signed [31:0] VXO [5] = '{32'sd61887744, 32'sd68067414, 32'sd75388085, 32'sd68067414, 32'sd27788417};
  always #5 clk = ~clk;
  thv_cordic_log dut (
    .clk(clk),
    .rst_n(rst_n),
    .x(x),
    .y(y),
    .x_o(x_o),
    .y_o(y_o),
    .z_o(z_o)
  );
  task automatic chk(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp, input int tol);
    longint d;
    d = longint'(got) - longint'(exp);
    if (d < 0) d = -d;
    n_chk++;
    if (d <= longint'(tol)) n_pass++;
    else $display("FAIL %s: got %0d (0x%08h), expected %0d +/- %0d", tag, got, got, exp, tol);
  endtask
  task automatic check_result(input string tag, input int k);
    chk({tag, "_z"}, z_o, VZ[k], 1024);
    chk({tag, "_x"}, x_o, VXO[k], 8192);
    chk({tag, "_y"}, y_o, 32'sd0, 2048);
  endtask
  initial begin
    x = $urandom;
    y = $urandom;
    repeat (2) @(negedge clk);
    chk("rst_x", x_o, 32'sd0, 0);
    chk("rst_y", y_o, 32'sd0, 0);
    chk("rst_z", z_o, 32'sd0, 0);
    rst_n = 1'b1;
    x = '0;
    y = '0;
    acc = '0;
    repeat (20) begin
      @(negedge clk);
      acc = acc | x_o | y_o;
    end
    chk("release_xy", acc, 32'sd0, 0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      x = VX[k];
      y = VY[k];
      @(negedge clk);
      x = '0;
      y = '0;
      repeat (17) @(negedge clk);
      chk($sformatf("early%0d_x", k), x_o, 32'sd0, 0);
      @(negedge clk);
      check_result($sformatf("case%0d", k), k);
    end
    repeat (20) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      x = VX[k];
      y = VY[k];
      @(negedge clk);
    end
    x = '0;
    y = '0;
    repeat (16) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check_result($sformatf("pipe%0d", k), k);
      @(negedge clk);
    end
    chk("pipe_tail_x", x_o, 32'sd0, 0);
    repeat (20) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      x = VX[k];
      y = VY[k];
      @(negedge clk);
    end
    x = '0;
    y = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("mid_rst_x", x_o, 32'sd0, 0);
    chk("mid_rst_y", y_o, 32'sd0, 0);
    chk("mid_rst_z", z_o, 32'sd0, 0);
    acc = '0;
    repeat (25) begin
      @(negedge clk);
      acc = acc | x_o | y_o;
    end
    chk("no_stale_xy", acc, 32'sd0, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
